// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and dispatch: a circular FIFO of fetch packets
// with a registered head, tail and occupancy count, flushed by squash or reset.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif

package inst_buffer_pkg;
    parameter int          XLEN = `XLEN;
    parameter logic [31:0] NOP  = `NOP;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
    } IF_IB_PACKET;
endpackage

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int IB_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  IF_IB_PACKET                   if_ib_packet,
    input  logic                          dp_ready,
    input  logic                          squash,
    output IF_IB_PACKET                   ib_dp_packet,
    output logic                          ib_full,
    output logic                          ib_empty,
    output logic [$clog2(IB_DEPTH+1)-1:0] ib_count
);
    localparam int PTR_W = $clog2(IB_DEPTH);
    localparam int CNT_W = $clog2(IB_DEPTH+1);

    IF_IB_PACKET        r_mem [IB_DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign ib_count = r_count;
    assign ib_full  = (r_count == CNT_W'(IB_DEPTH));
    assign ib_empty = (r_count == '0);

    // Full blocks push even when dispatch drains the head in the same cycle.
    assign w_push = if_ib_packet.valid && !ib_full  && !squash && !reset;
    assign w_pop  = dp_ready           && !ib_empty && !squash && !reset;

    // Pointers wrap naturally since IB_DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry contents are never cleared; only the pointers decide what is live.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_tail] <= if_ib_packet;
    end

    always_comb begin
        ib_dp_packet      = '0;
        ib_dp_packet.inst = NOP;
        if (!ib_empty) begin
            ib_dp_packet       = r_mem[r_head];
            ib_dp_packet.valid = 1'b1;
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer: fill, drain, latency, wrap,
// full-with-pop, squash and mid-stream reset scenarios.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam logic [31:0] EXP_NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    IF_IB_PACKET if_ib_packet;
    logic        dp_ready;
    logic        squash;
    IF_IB_PACKET ib_dp_packet;
    logic        ib_full;
    logic        ib_empty;
    logic [3:0]  ib_count;

    int vecCount  = 0;
    int missCount = 0;

    inst_buffer #(.IB_DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .if_ib_packet (if_ib_packet),
        .dp_ready     (dp_ready),
        .squash       (squash),
        .ib_dp_packet (ib_dp_packet),
        .ib_full      (ib_full),
        .ib_empty     (ib_empty),
        .ib_count     (ib_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic IF_IB_PACKET mk(input logic [31:0] pc);
        IF_IB_PACKET p;
        p.valid = 1'b1;
        p.inst  = 32'hA000_0000 | pc;
        p.PC    = pc;
        p.NPC   = pc + 32'd4;
        return p;
    endfunction

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        if_ib_packet = '0;
        dp_ready     = 1'b0;
        squash       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        vecCount++; if (ib_count !== 4'd0) begin missCount++; $display("[TB] FAIL reset_count got %0d want 0", ib_count); end
        vecCount++; if (ib_empty !== 1'b1) begin missCount++; $display("[TB] FAIL reset_empty got %b want 1", ib_empty); end
        vecCount++; if (ib_full !== 1'b0) begin missCount++; $display("[TB] FAIL reset_full got %b want 0", ib_full); end
        vecCount++; if (ib_dp_packet.valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid got %b want 0", ib_dp_packet.valid); end
        vecCount++; if (ib_dp_packet.inst !== EXP_NOP) begin missCount++; $display("[TB] FAIL reset_inst got %h want %h", ib_dp_packet.inst, EXP_NOP); end
        vecCount++; if (ib_dp_packet.PC !== 32'h0) begin missCount++; $display("[TB] FAIL reset_pc got %h want 0", ib_dp_packet.PC); end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        if_ib_packet       = mk(32'h999);
        if_ib_packet.valid = 1'b0;
        tick();
        vecCount++; if (ib_count !== 4'd0) begin missCount++; $display("[TB] FAIL invalid_drop got %0d want 0", ib_count); end
        for (int i = 0; i < 8; i++) begin
            if_ib_packet = mk(32'(4 * i));
            tick();
        end
        vecCount++; if (ib_count !== 4'd8) begin missCount++; $display("[TB] FAIL fill_count got %0d want 8", ib_count); end
        vecCount++; if (ib_full !== 1'b1) begin missCount++; $display("[TB] FAIL fill_full got %b want 1", ib_full); end
        if_ib_packet = mk(32'h20);
        tick();
        idle();
        vecCount++; if (ib_count !== 4'd8) begin missCount++; $display("[TB] FAIL overflow_count got %0d want 8", ib_count); end
        vecCount++; if (ib_dp_packet.PC !== 32'h0) begin missCount++; $display("[TB] FAIL overflow_head got %h want 0", ib_dp_packet.PC); end
    endtask

    task automatic test_drain();
        dp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vecCount++; if (ib_dp_packet.PC !== 32'(4 * i) || ib_dp_packet.valid !== 1'b1) begin missCount++; $display("[TB] FAIL drain_pc[%0d] got %h/%b want %h/1", i, ib_dp_packet.PC, ib_dp_packet.valid, 32'(4 * i)); end
            tick();
        end
        dp_ready = 1'b0;
        vecCount++; if (ib_empty !== 1'b1) begin missCount++; $display("[TB] FAIL drain_empty got %b want 1", ib_empty); end
        vecCount++; if (ib_dp_packet.valid !== 1'b0 || ib_dp_packet.inst !== EXP_NOP) begin missCount++; $display("[TB] FAIL drain_out got %b/%h want 0/%h", ib_dp_packet.valid, ib_dp_packet.inst, EXP_NOP); end
    endtask

    task automatic test_latency_wrap();
        if_ib_packet = mk(32'h100);
        #1;
        vecCount++; if (ib_dp_packet.valid !== 1'b0) begin missCount++; $display("[TB] FAIL bypass_valid got %b want 0", ib_dp_packet.valid); end
        tick();
        vecCount++; if (ib_dp_packet.valid !== 1'b1 || ib_dp_packet.PC !== 32'h100) begin missCount++; $display("[TB] FAIL latency_out got %b/%h want 1/100", ib_dp_packet.valid, ib_dp_packet.PC); end
        vecCount++; if (ib_dp_packet.inst !== 32'hA000_0100) begin missCount++; $display("[TB] FAIL latency_inst got %h want a0000100", ib_dp_packet.inst); end
        if_ib_packet = mk(32'h104);
        tick();
        if_ib_packet = mk(32'h108);
        tick();
        for (int i = 0; i < 20; i++) begin
            if_ib_packet = mk(32'h10C + 32'(4 * i));
            dp_ready     = 1'b1;
            vecCount++; if (ib_dp_packet.PC !== 32'h100 + 32'(4 * i)) begin missCount++; $display("[TB] FAIL stream_pc[%0d] got %h want %h", i, ib_dp_packet.PC, 32'h100 + 32'(4 * i)); end
            tick();
            vecCount++; if (ib_count !== 4'd3) begin missCount++; $display("[TB] FAIL stream_count[%0d] got %0d want 3", i, ib_count); end
        end
        if_ib_packet = '0;
        for (int i = 0; i < 3; i++) begin
            vecCount++; if (ib_dp_packet.PC !== 32'h150 + 32'(4 * i)) begin missCount++; $display("[TB] FAIL stream_tail[%0d] got %h want %h", i, ib_dp_packet.PC, 32'h150 + 32'(4 * i)); end
            tick();
        end
        idle();
        vecCount++; if (ib_empty !== 1'b1) begin missCount++; $display("[TB] FAIL stream_empty got %b want 1", ib_empty); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) begin
            if_ib_packet = mk(32'h300 + 32'(4 * i));
            tick();
        end
        if_ib_packet = mk(32'h40);
        dp_ready     = 1'b1;
        tick();
        if_ib_packet = '0;
        vecCount++; if (ib_count !== 4'd7 || ib_full !== 1'b0) begin missCount++; $display("[TB] FAIL fullpop_count got %0d/%b want 7/0", ib_count, ib_full); end
        for (int i = 1; i < 8; i++) begin
            vecCount++; if (ib_dp_packet.PC !== 32'h300 + 32'(4 * i)) begin missCount++; $display("[TB] FAIL fullpop_pc[%0d] got %h want %h", i, ib_dp_packet.PC, 32'h300 + 32'(4 * i)); end
            tick();
        end
        idle();
        vecCount++; if (ib_empty !== 1'b1) begin missCount++; $display("[TB] FAIL fullpop_empty got %b want 1", ib_empty); end
    endtask

    task automatic test_squash();
        for (int i = 0; i < 5; i++) begin
            if_ib_packet = mk(32'h500 + 32'(4 * i));
            tick();
        end
        vecCount++; if (ib_count !== 4'd5) begin missCount++; $display("[TB] FAIL squash_pre got %0d want 5", ib_count); end
        if_ib_packet = mk(32'h600);
        dp_ready     = 1'b1;
        squash       = 1'b1;
        tick();
        idle();
        vecCount++; if (ib_count !== 4'd0 || ib_empty !== 1'b1 || ib_dp_packet.valid !== 1'b0) begin missCount++; $display("[TB] FAIL squash_flush got %0d/%b/%b want 0/1/0", ib_count, ib_empty, ib_dp_packet.valid); end
        if_ib_packet = mk(32'h200);
        tick();
        idle();
        vecCount++; if (ib_dp_packet.PC !== 32'h200 || ib_count !== 4'd1) begin missCount++; $display("[TB] FAIL squash_next got %h/%0d want 200/1", ib_dp_packet.PC, ib_count); end
        dp_ready = 1'b1;
        tick();
        tick();
        dp_ready = 1'b0;
        vecCount++; if (ib_count !== 4'd0 || ib_empty !== 1'b1) begin missCount++; $display("[TB] FAIL empty_pop got %0d/%b want 0/1", ib_count, ib_empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            if_ib_packet = mk(32'h700 + 32'(4 * i));
            tick();
        end
        vecCount++; if (ib_count !== 4'd4) begin missCount++; $display("[TB] FAIL rstmid_pre got %0d want 4", ib_count); end
        if_ib_packet = mk(32'h800);
        dp_ready     = 1'b1;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        vecCount++; if (ib_count !== 4'd0 || ib_empty !== 1'b1 || ib_full !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_state got %0d/%b/%b want 0/1/0", ib_count, ib_empty, ib_full); end
        vecCount++; if (ib_dp_packet.valid !== 1'b0 || ib_dp_packet.inst !== EXP_NOP) begin missCount++; $display("[TB] FAIL rstmid_out got %b/%h want 0/%h", ib_dp_packet.valid, ib_dp_packet.inst, EXP_NOP); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_latency_wrap();
        test_full_pop();
        test_squash();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
